stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count resolution in Hz (10 ms).
REQ-003 SHALL have parameter REFRESH_HZ, default 1000, digit-scan rate in Hz.
REQ-004 SHALL have parameter NUM_DIGITS, default 8, legal range 2..8, count of BCD digits displayed.
REQ-005 SHALL have port clk_in, input, 1, single system clock; every flop is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port start_stop, input, 1, level button; each rising edge toggles run/stop.
REQ-008 SHALL have port lap, input, 1, level button; each rising edge toggles lap hold.
REQ-009 SHALL have port clear, input, 1, level button; a rising edge zeroes the count.
REQ-010 SHALL have port AN, output, NUM_DIGITS, active-low digit anode enables.
REQ-011 SHALL have port CAT, output, 7, active-low segments, with bit6=a through bit0=g.
REQ-012 SHALL have port running, output, 1, high in the RUN and LAP states.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when the count wraps.

Function
REQ-014 SHALL pass each button through a 2-flop synchroniser and a rising-edge detector; the resulting internal pulse is 1 cycle wide and asserts 3 clk_in edges after the input rises.
REQ-015 SHALL derive all timing from clock enables only, with no generated or divided clocks.
REQ-016 SHALL run a tick prescaler from 0 to CLK_HZ/TICK_HZ-1; a 1-cycle tick asserts at the terminal value.
REQ-017 SHALL advance the prescaler only in RUN or LAP, and SHALL reset the prescaler to 0 on entry to RUN from STOP.
REQ-018 SHALL hold the count as NUM_DIGITS cascaded BCD decade counters, each digit 0..9; digit 0 is least significant.
REQ-019 SHALL increment digit 0 on each tick; a digit carries into the next only when it is 9 and has a carry-in.
REQ-020 SHALL, when all digits are 9 at a tick, wrap every digit to 0 and set overflow.
REQ-021 SHALL implement FSM states STOP, RUN and LAP.
  - STOP + start_stop -> RUN
  - RUN + start_stop -> STOP
  - RUN + lap -> LAP, latching the count into the display register
  - LAP + lap -> RUN
  - LAP + start_stop -> STOP, with the display showing the live count
REQ-022 SHALL make clear zero the count, the prescaler and overflow only in STOP; clear is ignored in RUN and LAP.
REQ-023 SHALL make lap in STOP ignored.
REQ-024 SHALL resolve simultaneous pulses with priority start_stop > lap > clear.
REQ-025 SHALL count a tick that coincides with a stop transition, so the count increments once more.
REQ-026 SHALL select the displayed value as the live count in STOP and RUN, and the latched count in LAP.
REQ-027 SHALL run a refresh prescaler from 0 to CLK_HZ/(REFRESH_HZ*NUM_DIGITS)-1; at its terminal value the digit index advances, wrapping from NUM_DIGITS-1 to 0.
REQ-028 SHALL, for digit index i, drive AN with bit i low and all others high, and drive CAT with the decode of displayed digit i.
  - AN and CAT are registered and update together on the same cycle.
REQ-029 SHALL decode CAT as follows:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - any other value=1111111
REQ-030 SHALL fail elaboration if CLK_HZ/TICK_HZ < 2, if CLK_HZ/(REFRESH_HZ*NUM_DIGITS) < 1, or if NUM_DIGITS is outside 2..8.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force:
  - FSM=STOP
  - count, latch, both prescalers and digit index = 0
  - synchroniser and edge-detector flops = 0
  - AN = all ones, CAT = 1111111, running = 0, overflow = 0
REQ-032 SHALL make reset asserted mid-RUN or mid-LAP discard all state; after release the block is in STOP with count 0.
REQ-033 SHALL make a button held high through reset release produce no pulse.

Verification
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), REFRESH_HZ=250, NUM_DIGITS=4 (refresh every 1 cycle).

REQ-034 SHALL cover basic counting:
  - Stimulus: pulse start_stop, then wait 1000 cycles, then pulse start_stop.
  - Response: count = 0100 ±1 LSB; running falls 4 cycles after the second edge; AN scans 1110, 1101, 1011, 0111 repeatedly.
REQ-035 SHALL cover lap hold:
  - Stimulus: in RUN at count 0025, pulse lap; run 200 cycles; pulse lap.
  - Response: display stays 0025 during the hold while the live count reaches about 0045; the display jumps to the live value after the second lap.
REQ-036 SHALL cover overflow:
  - Stimulus: preload count 9999 via run time, then apply one tick.
  - Response: count = 0000 and overflow = 1; a clear in STOP returns overflow to 0.
REQ-037 SHALL cover clear gating and priority:
  - Stimulus 1: clear in RUN.
  - Response 1: count unchanged.
  - Stimulus 2: start_stop and clear on the same cycle in STOP.
  - Response 2: enters RUN, count not cleared.
REQ-038 SHALL cover async reset:
  - Stimulus: drop rst_n mid-cycle during LAP.
  - Response: AN = 1111 and CAT = 1111111 immediately, without waiting for a clock edge; after release, FSM = STOP and count = 0000.
REQ-039 SHALL cover digit decode:
  - Stimulus: force each displayed digit value 0..9 in turn.
  - Response: CAT matches the REQ-029 table for each value.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// BCD stopwatch: synchronised buttons drive a STOP/RUN/LAP FSM over cascaded decade counters,
// with a time-multiplexed 7-segment scan. Buttons act 4 cycles after rising; no backpressure.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            CAT,
  output logic                  running,
  output logic                  overflow
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int REF_DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int RW       = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int IW       = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW       = 4 * NUM_DIGITS;

  if (TICK_DIV < 2 || REF_DIV < 1 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_params
    $error("stopwatch_ctrl: illegal CLK_HZ/TICK_HZ/REFRESH_HZ/NUM_DIGITS combination");
  end

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LAP} state_t;

  state_t          state;
  logic [2:0]      btn, sync1, sync2, sync3, pulse, rel;
  logic            ss_p, lap_p, clr_p;
  logic [TW-1:0]   presc;
  logic            tick;
  logic [DW-1:0]   cnt, cnt_inc, latch, disp;
  logic            carry;
  logic [RW-1:0]   rpresc;
  logic [IW-1:0]   idx;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign btn = {clear, lap, start_stop};

  // rel masks the detector until the chain holds post-reset samples, so a
  // button held through reset release never looks like a fresh press.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      pulse <= '0;
      rel   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      rel   <= {rel[1:0], 1'b1};
      pulse <= sync2 & ~sync3 & {3{rel[2]}};
    end
  end

  assign ss_p  = pulse[0];
  assign lap_p = pulse[1];
  assign clr_p = pulse[2];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      running <= 1'b0;
      latch   <= '0;
    end else begin
      case (state)
        ST_STOP: if (ss_p) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: if (ss_p) begin
          state   <= ST_STOP;
          running <= 1'b0;
        end else if (lap_p) begin
          state <= ST_LAP;
          latch <= cnt;
        end
        ST_LAP: if (ss_p) begin
          state   <= ST_STOP;
          running <= 1'b0;
        end else if (lap_p) begin
          state <= ST_RUN;
        end
        default: begin
          state   <= ST_STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign tick = (state != ST_STOP) && (presc == TW'(TICK_DIV - 1));

  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // A tick on the stop edge still lands because tick is qualified by the current state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == ST_STOP) begin
        if (ss_p) begin
          presc <= '0;
        end else if (clr_p) begin
          presc    <= '0;
          cnt      <= '0;
          overflow <= 1'b0;
        end
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        cnt <= cnt_inc;
        if (carry) overflow <= 1'b1;
      end
    end
  end

  assign disp = (state == ST_LAP) ? latch : cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rpresc <= '0;
      idx    <= '0;
      AN     <= '1;
      CAT    <= 7'b1111111;
    end else begin
      if (rpresc == RW'(REF_DIV - 1)) begin
        rpresc <= '0;
        idx    <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        rpresc <= rpresc + 1'b1;
      end
      AN  <= ~(NUM_DIGITS'(1) << idx);
      CAT <= seg7(disp[4*idx +: 4]);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised button sequences against an arithmetic elapsed-time model of the stopwatch.
module tb_stopwatch_ctrl;
  logic       clk_in = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] AN;
  logic [6:0] CAT;
  logic       running, overflow;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .REFRESH_HZ(250), .NUM_DIGITS(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start_stop(start_stop), .lap(lap), .clear(clear),
    .AN(AN), .CAT(CAT), .running(running), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model: count = base + whole 10-cycle periods elapsed since the RUN entry edge.
  typedef enum int {M_STOP, M_RUN, M_LAP} mode_t;
  mode_t m_mode = M_STOP;
  int    m_base = 0, m_entry = 0, m_latch = 0, m_ovf = 0;

  function automatic int live_at(input int k);
    return (m_base + (k - m_entry) / 10) % 10000;
  endfunction

  task automatic model_reset();
    m_mode = M_STOP; m_base = 0; m_entry = 0; m_latch = 0; m_ovf = 0;
  endtask

  task automatic press(input bit s, input bit l, input bit c);
    int n, e, t, old_run;
    @(negedge clk_in);
    n = cyc; e = n + 4;
    old_run = (m_mode != M_STOP) ? 1 : 0;
    start_stop = s; lap = l; clear = c;
    if (s) begin
      if (m_mode == M_STOP) begin
        m_mode = M_RUN; m_entry = e;
      end else begin
        t = m_base + (e - m_entry) / 10;
        if (t >= 10000) m_ovf = 1;
        m_base = t % 10000; m_mode = M_STOP;
      end
    end else if (l && m_mode != M_STOP) begin
      if (m_mode == M_RUN) begin
        m_latch = live_at(e - 1); m_mode = M_LAP;
      end else begin
        m_mode = M_RUN;
      end
    end else if (c && m_mode == M_STOP) begin
      m_base = 0; m_ovf = 0;
    end
    repeat (3) @(negedge clk_in);
    check_eq("run_before_edge4", int'(running), old_run);
    @(negedge clk_in);
    check_eq("run_after_edge4", int'(running), (m_mode != M_STOP) ? 1 : 0);
    repeat (2) @(negedge clk_in);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic read_disp(output int val);
    int seen, p, d, w;
    bit bad;
    seen = 0; bad = 1'b0; val = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_in);
      p = -1; d = -1;
      for (int b = 0; b < 4; b++) if (AN == ~(4'b0001 << b)) p = b;
      for (int v = 0; v < 10; v++) if (CAT == seg_tab[v]) d = v;
      if (p < 0 || d < 0) bad = 1'b1;
      else if (seen[p]) bad = 1'b1;
      else begin
        seen = seen | (1 << p);
        w = 1;
        for (int q = 0; q < p; q++) w = w * 10;
        val = val + d * w;
      end
    end
    if (bad || seen != 15) val = -1;
  endtask

  task automatic check_display(input string tag);
    int exp, got, guard;
    guard = 0;
    if (m_mode == M_RUN) begin
      while (((cyc - m_entry) % 10) != 1 && guard < 20) begin
        @(negedge clk_in);
        guard++;
      end
      exp = live_at(cyc);
    end else begin
      exp = (m_mode == M_LAP) ? m_latch : m_base;
    end
    read_disp(got);
    check_eq(tag, got, exp);
    check_eq({tag, "_running"}, int'(running), (m_mode != M_STOP) ? 1 : 0);
    check_eq({tag, "_overflow"}, int'(overflow), m_ovf);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got, target, r;
    logic [3:0] an_prev, vv;

    // Asynchronous reset before any clock edge, with start_stop held through release.
    #1 rst_n = 1'b0;
    start_stop = 1'b1;
    #1;
    check_eq("rst_an", int'(AN), 15);
    check_eq("rst_cat", int'(CAT), 127);
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_in);
    start_stop = 1'b0;
    repeat (8) @(negedge clk_in);
    check_display("held_button_no_pulse");

    // Basic counting and anode scan order.
    press(1, 0, 0);
    repeat (1000) @(negedge clk_in);
    press(1, 0, 0);
    check_display("basic_count");
    @(negedge clk_in);
    an_prev = AN;
    check_eq("an_onehot", $countones(~an_prev), 1);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk_in);
      check_eq("an_scan", int'(AN), int'({an_prev[2:0], an_prev[3]}));
      an_prev = AN;
    end

    // Lap hold at 0025.
    press(0, 0, 1);
    check_display("clear_stop");
    press(1, 0, 0);
    target = (m_entry - 4) + 256 + $urandom_range(0, 9);
    while (cyc < target - 1) @(negedge clk_in);
    press(0, 1, 0);
    read_disp(got);
    check_eq("lap_latch_0025", got, 25);
    repeat (200) @(negedge clk_in);
    check_display("lap_hold");
    press(0, 1, 0);
    check_display("lap_release_live");

    // Clear ignored in RUN; start_stop beats clear in STOP.
    press(0, 0, 1);
    check_display("clear_in_run");
    press(1, 0, 0);
    check_display("stopped");
    press(1, 0, 1);
    check_display("ss_beats_clear");
    press(1, 0, 0);

    // Randomised button sequences.
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      press(r < 3 || r == 9, (r >= 3 && r <= 5) || r == 8, r >= 6);
      repeat ($urandom_range(0, 150)) @(negedge clk_in);
      check_display("random");
    end
    if (m_mode != M_STOP) press(1, 0, 0);

    // Overflow: accelerate to 9999 with forced ticks, then one more tick.
    press(0, 0, 1);
    @(negedge clk_in);
    force dut.tick = 1'b1;
    repeat (9999) @(negedge clk_in);
    release dut.tick;
    m_base = 9999;
    check_display("preload_9999");
    @(negedge clk_in);
    force dut.tick = 1'b1;
    @(negedge clk_in);
    release dut.tick;
    m_base = 0; m_ovf = 1;
    check_display("wrap_to_0000");
    check_eq("overflow_set", int'(overflow), 1);
    press(0, 0, 1);
    check_display("clear_overflow");

    // Segment decode for every nibble value.
    for (int v = 0; v < 16; v++) begin
      vv = v[3:0];
      @(negedge clk_in);
      force dut.disp = {4{vv}};
      repeat (2) @(negedge clk_in);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk_in);
        check_eq("cat_decode", int'(CAT), (v < 10) ? int'(seg_tab[v]) : 127);
      end
    end
    release dut.disp;

    // Reset mid-cycle during LAP.
    press(1, 0, 0);
    repeat (300) @(negedge clk_in);
    press(0, 1, 0);
    check_display("pre_reset_lap");
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_an", int'(AN), 15);
    check_eq("async_rst_cat", int'(CAT), 127);
    check_eq("async_rst_running", int'(running), 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk_in);
    check_display("after_reset");
    press(1, 0, 0);
    repeat (50) @(negedge clk_in);
    press(1, 0, 0);
    check_display("count_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
